// File: rtl/shift_word_receiver_pkg.sv
// Shared types and constants for the serial-in/parallel-out word receiver.
package shift_rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage : shift_rx_pkg

// File: rtl/shift_word_receiver_if.sv
// Serial link, parallel output handshake and status signals of the word receiver.
interface shift_word_receiver_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             dir;
    logic             ser_in;
    logic             ser_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             clr_ovr;

    modport master (
        output start, dir, ser_in, ser_valid, out_ready, clr_ovr,
        input  out, out_valid, busy, overrun
    );

    modport slave (
        input  start, dir, ser_in, ser_valid, out_ready, clr_ovr,
        output out, out_valid, busy, overrun
    );
endinterface : shift_word_receiver_if

// File: rtl/shift_word_receiver_bit_counter.sv
// Counts accepted serial bits of the current word and flags the one that completes it.
module shift_rx_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: clear wins, otherwise increment and saturate at WIDTH.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (en && (count_q != CNT_W'(WIDTH))) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = en && (count_q == CNT_W'(WIDTH - 1));

endmodule : shift_rx_bit_counter

// File: rtl/shift_word_receiver.sv
// Serial-in/parallel-out receiver: assembles WIDTH bits MSB- or LSB-first into a
// single-entry output buffer with valid/ready handshake and a sticky overrun flag.
module shift_word_receiver
    import shift_rx_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_word_receiver_if.slave  bus
);

    state_e           state_d,     state_q;
    logic             dir_d,       dir_q;
    logic [WIDTH-1:0] sreg_d,      sreg_q;
    logic [WIDTH-1:0] out_d,       out_q;
    logic             out_valid_d, out_valid_q;
    logic             busy_d,      busy_q;
    logic             overrun_d,   overrun_q;

    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             cnt_last_s;
    logic [CNT_W-1:0] cnt_s;
    logic [WIDTH-1:0] sreg_shift_s;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic             lsb_first,
                                                  input logic             bit_in);
        logic [WIDTH-1:0] nxt;
        if (lsb_first) begin
            nxt = {bit_in, cur[WIDTH-1:1]};
        end else begin
            nxt = {cur[WIDTH-2:0], bit_in};
        end
        return nxt;
    endfunction

    shift_rx_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .count (cnt_s),
        .last  (cnt_last_s)
    );

    assign sreg_shift_s = shift_in(sreg_q, (dir_q == DIR_LSB_FIRST), bus.ser_in);

    // Next-state, shift and output-buffer decisions.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        sreg_d      = sreg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // A completion below may set overrun again; that later assignment wins.
        if (bus.clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SHIFT;
                    dir_d     = bus.dir;
                    sreg_d    = {WIDTH{1'b0}};
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bus.ser_valid && (cnt_s != CNT_W'(WIDTH))) begin
                    cnt_en_s = 1'b1;
                    sreg_d   = sreg_shift_s;
                    if (cnt_last_s) begin
                        state_d = IDLE;
                        if (!out_valid_q || bus.out_ready) begin
                            out_d       = sreg_shift_s;
                            out_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dir_q       <= DIR_MSB_FIRST;
            sreg_q      <= {WIDTH{1'b0}};
            out_q       <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            sreg_q      <= sreg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule : shift_word_receiver

// File: tb/tb_shift_word_receiver.sv
// Directed self-checking bench for shift_word_receiver with WIDTH=4.
module tb_shift_word_receiver;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    shift_word_receiver_if #(.WIDTH(4)) bus ();

    shift_word_receiver #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic d);
        bus.start = 1'b1;
        bus.dir   = d;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.ser_valid = 1'b1;
        bus.ser_in    = b;
        tick();
        bus.ser_valid = 1'b0;
    endtask

    // bits[3] arrives first
    task automatic send_word(input logic d, input logic [3:0] bits);
        pulse_start(d);
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++; if (bus.out !== 4'b0000) begin errors++; $display("FAIL reset_out got %b exp 0000", bus.out); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
        #4;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_msb_first();
        logic [3:0] bits;
        bits = 4'b1011;
        bus.out_ready = 1'b1;
        pulse_start(1'b0);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL msb_busy_start got %b exp 1", bus.busy); end
        for (int i = 3; i >= 1; i--) begin
            send_bit(bits[i]);
            checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL msb_mid busy %b valid %b exp 1 0", bus.busy, bus.out_valid); end
        end
        send_bit(bits[0]);
        checks++; if (bus.out !== 4'b1011) begin errors++; $display("FAIL msb_out got %b exp 1011", bus.out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL msb_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL msb_busy_end got %b exp 0", bus.busy); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL msb_consumed got %b exp 0", bus.out_valid); end
        checks++; if (bus.out !== 4'b1011) begin errors++; $display("FAIL msb_out_hold got %b exp 1011", bus.out); end
    endtask

    task automatic test_lsb_first();
        bus.out_ready = 1'b1;
        send_word(1'b1, 4'b1101);
        checks++; if (bus.out !== 4'b1011) begin errors++; $display("FAIL lsb_out got %b exp 1011", bus.out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b exp 1", bus.out_valid); end
        tick();
    endtask

    task automatic test_gaps();
        bus.out_ready = 1'b1;
        pulse_start(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL gap_busy1 got %b exp 1", bus.busy); end
        bus.start = 1'b1;
        bus.dir   = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL gap_busy2 got %b exp 1", bus.busy); end
        send_bit(1'b1);
        checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL gap_busy3 busy %b valid %b exp 1 0", bus.busy, bus.out_valid); end
        send_bit(1'b0);
        checks++; if (bus.out !== 4'b0110) begin errors++; $display("FAIL gap_out got %b exp 0110", bus.out); end
        checks++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL gap_end valid %b busy %b exp 1 0", bus.out_valid, bus.busy); end
        bus.dir = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back_overrun();
        bus.out_ready = 1'b0;
        send_word(1'b0, 4'b1100);
        checks++; if (bus.out !== 4'b1100 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first out %b valid %b exp 1100 1", bus.out, bus.out_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr got %b exp 0", bus.overrun); end
        send_word(1'b0, 4'b0011);
        checks++; if (bus.out !== 4'b1100) begin errors++; $display("FAIL ovr_out_kept got %b exp 1100", bus.out); end
        checks++; if (bus.overrun !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovr_set ovr %b valid %b exp 1 1", bus.overrun, bus.out_valid); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovr_consume got %b exp 0", bus.out_valid); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", bus.overrun); end
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", bus.overrun); end
    endtask

    task automatic test_set_wins();
        bus.out_ready = 1'b0;
        send_word(1'b0, 4'b1111);
        pulse_start(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        bus.clr_ovr = 1'b1;
        send_bit(1'b0);
        bus.clr_ovr = 1'b0;
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", bus.overrun); end
        checks++; if (bus.out !== 4'b1111) begin errors++; $display("FAIL set_wins_out got %b exp 1111", bus.out); end
        bus.clr_ovr   = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.clr_ovr   = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (bus.overrun !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL set_wins_clear ovr %b valid %b exp 0 0", bus.overrun, bus.out_valid); end
    endtask

    task automatic test_consume_and_complete();
        bus.out_ready = 1'b0;
        send_word(1'b0, 4'b1010);
        pulse_start(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        bus.out_ready = 1'b1;
        send_bit(1'b1);
        bus.out_ready = 1'b0;
        checks++; if (bus.out !== 4'b0101) begin errors++; $display("FAIL cc_out got %b exp 0101", bus.out); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cc_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL cc_overrun got %b exp 0", bus.overrun); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL cc_hold got %b exp 1", bus.out_valid); end
    endtask

    task automatic test_reset_mid_word();
        bus.out_ready = 1'b0;
        pulse_start(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b0;
        #1;
        checks++; if (bus.out !== 4'b0000 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmw_out out %b valid %b exp 0000 0", bus.out, bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmw_busy got %b exp 0", bus.busy); end
        #2;
        rst = 1'b1;
        tick();
        send_bit(1'b1);
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmw_idle busy %b valid %b exp 0 0", bus.busy, bus.out_valid); end
        send_word(1'b0, 4'b1001);
        checks++; if (bus.out !== 4'b1001 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmw_fresh out %b valid %b exp 1001 1", bus.out, bus.out_valid); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.dir       = 1'b0;
        bus.ser_in    = 1'b0;
        bus.ser_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr_ovr   = 1'b0;

        test_reset();
        test_msb_first();
        test_lsb_first();
        test_gaps();
        test_back_to_back_overrun();
        test_set_wins();
        test_consume_and_complete();
        test_reset_mid_word();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_word_receiver
